// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
// Imported by the MEM-stage data memory.
package mips_pkg;

    localparam int DATA_W = 32;

    typedef logic [31:0] word_t;

    localparam word_t WORD_ZERO = 32'h0000_0000;

endpackage

// File: rtl/data_memory_ram.sv
// MEM-stage data memory: word-addressed RAM with
// combinational read, clocked write and async clear.
module data_memory_ram
    import mips_pkg::*;
#(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] mem_d [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              unused_addr;

    // Byte offset and high bits are dropped: aligned, wrapping access.
    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^{addr[1:0], addr[31:IDX_W+2]};

    always_comb begin
        mem_d = mem_q;
        if (mem_write == 1'b1) begin
            mem_d[idx] = write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign read_data = reset_n ? mem_q[idx] : DATA_W'(WORD_ZERO);

endmodule

// File: tb/tb_data_memory_ram.sv
// Directed self-checking bench for data_memory_ram.
// Inputs change on negedge; outputs sampled between edges.
module tb_data_memory_ram;

    logic        clk;
    logic        reset_n;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int checks;
    int failures;

    data_memory_ram dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_write  (mem_write),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_write  = 1'b1;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0;
        addrs[1] = 32'h4;
        addrs[2] = 32'hFFC;
        reset_n    = 1'b0;
        mem_write  = 1'b0;
        addr       = 32'h0;
        write_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", read_data, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        foreach (addrs[i]) begin
            addr = addrs[i];
            #1;
            checks++;
            if (read_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_read a=%h got=%h exp=%h",
                         addrs[i], read_data, 32'h0);
            end
        end
    endtask

    task automatic test_write_read;
        do_write(32'h10, 32'hDEADBEEF);
        @(negedge clk);
        addr = 32'h0;
        #1;
        addr = 32'h10;
        #1;
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_read got=%h exp=%h", read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_write_disable;
        @(negedge clk);
        mem_write  = 1'b0;
        addr       = 32'h10;
        write_data = 32'h12345678;
        @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_disable got=%h exp=%h",
                     read_data, 32'hDEADBEEF);
        end
    endtask

    task automatic test_align_wrap;
        do_write(32'h13, 32'hA5A5A5A5);
        addr = 32'h10;
        #1;
        checks++;
        if (read_data !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL align got=%h exp=%h", read_data, 32'hA5A5A5A5);
        end
        do_write(32'h1000, 32'h11111111);
        addr = 32'h0;
        #1;
        checks++;
        if (read_data !== 32'h11111111) begin
            failures++;
            $display("FAIL wrap got=%h exp=%h", read_data, 32'h11111111);
        end
        do_write(32'hFFC, 32'hCAFEF00D);
        addr = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (read_data !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL top_word got=%h exp=%h", read_data, 32'hCAFEF00D);
        end
        addr = 32'h4;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL neighbour got=%h exp=%h", read_data, 32'h0);
        end
    endtask

    task automatic test_read_during_write;
        do_write(32'h20, 32'h1);
        @(negedge clk);
        addr       = 32'h20;
        mem_write  = 1'b1;
        write_data = 32'h2;
        #1;
        checks++;
        if (read_data !== 32'h1) begin
            failures++;
            $display("FAIL rdw_before got=%h exp=%h", read_data, 32'h1);
        end
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        checks++;
        if (read_data !== 32'h2) begin
            failures++;
            $display("FAIL rdw_after got=%h exp=%h", read_data, 32'h2);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] addrs [5];
        addrs[0] = 32'h40;
        addrs[1] = 32'h44;
        addrs[2] = 32'h10;
        addrs[3] = 32'h0;
        addrs[4] = 32'hFFC;
        do_write(32'h40, 32'h55);
        do_write(32'h44, 32'h66);
        addr = 32'h44;
        #1;
        checks++;
        if (read_data !== 32'h66) begin
            failures++;
            $display("FAIL pre_reset got=%h exp=%h", read_data, 32'h66);
        end
        @(negedge clk);
        #2;
        addr       = 32'h40;
        mem_write  = 1'b1;
        write_data = 32'h77;
        reset_n    = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", read_data, 32'h0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_no_write got=%h exp=%h", read_data, 32'h0);
        end
        @(negedge clk);
        mem_write = 1'b0;
        reset_n   = 1'b1;
        foreach (addrs[i]) begin
            addr = addrs[i];
            #1;
            checks++;
            if (read_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_clear a=%h got=%h exp=%h",
                         addrs[i], read_data, 32'h0);
            end
        end
    endtask

    task automatic test_first_write_after_reset;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        mem_write  = 1'b1;
        addr       = 32'h48;
        write_data = 32'h99;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        checks++;
        if (read_data !== 32'h99) begin
            failures++;
            $display("FAIL first_write got=%h exp=%h", read_data, 32'h99);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_write_disable();
        test_align_wrap();
        test_read_during_write();
        test_reset_mid();
        test_first_write_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
